rev_gate_engine: RTL and testbench
==================================

# rev_gate_engine

Parametrised, sequential reversible-logic engine. It holds a programmable list of up to DEPTH generalised gates and applies them in order to WIDTH-bit data words. Each gate is either a multi-control Toffoli or a multi-control Fredkin. Input and output use valid/ready handshakes, and the engine applies one gate per clock. It is the general-purpose successor to our fixed Toffoli/Fredkin gate macros, and adds an optional inverse (uncompute) mode.

## Interface
- WIDTH, 8, data word width in bits (≥2)
- DEPTH, 16, gate program entries
- IDXW, $clog2(WIDTH), bit-index width (derived)
- ADRW, $clog2(DEPTH), program address width (derived)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- prog_we  in  1  program write strobe
- prog_addr  in  ADRW  entry written
- prog_type  in  2  gate type: 00 NOP, 01 TOFFOLI, 10 FREDKIN, 11 NOP
- prog_ctrl  in  WIDTH  control mask; all-zero means unconditional
- prog_tgt_a  in  IDXW  target bit (Toffoli), first swap bit (Fredkin)
- prog_tgt_b  in  IDXW  second swap bit (Fredkin only)
- prog_len  in  ADRW+1  gate count; sampled at input accept
- in_valid / in_ready  in / out  1  input handshake
- in_data  in  WIDTH  word to transform
- in_inv  in  1  run the program in inverse order; sampled at accept
- out_valid / out_ready  out / in  1  output handshake
- out_data  out  WIDTH  transformed word
- busy  out  1  high in RUN and DONE

## Operation
- **Gate semantics.** Controls are satisfied when (state & ctrl) == ctrl.
  - TOFFOLI: flips bit tgt_a when controls are satisfied.
  - FREDKIN: swaps bits tgt_a and tgt_b when controls are satisfied.
- **Degenerate entries execute as NOP.** This keeps every entry self-inverse. An entry is a NOP when:
  - the ctrl mask includes any target bit, or
  - it is a FREDKIN with tgt_a == tgt_b, or
  - any target index is ≥ WIDTH.
- **State machine:** IDLE → RUN → DONE → IDLE.
  - IDLE: in_ready=1. When in_valid is high, latch in_data, inv and len = min(prog_len, DEPTH). Go to DONE if len==0, otherwise go to RUN with pc = 0 (forward) or len−1 (inverse).
  - RUN: apply entry pc to the state register once per cycle. pc steps +1 (forward) or −1 (inverse). After the last gate, go to DONE.
  - DONE: out_valid=1 and out_data = state. On out_valid && out_ready, return to IDLE.
- **Program writes.** prog_we is honoured only in IDLE. Writes in RUN or DONE are dropped silently, so the program stays stable during a run.
- **Reset values.**
  - Outputs: in_ready=1, out_valid=0, out_data=0, busy=0.
  - Internal: state=IDLE, all program entries NOP (type 00, ctrl 0, targets 0).
- **Reset mid-run.** Abandons the word immediately and applies the full reset values.

## Timing
- Accept edge is E; out_valid is high from edge E+len+1. A len==0 word is valid from E+1.
- Throughput: one word per len+2 cycles with out_ready held high.
- out_data and out_valid stay stable while out_ready=0. in_ready stays low for the whole of RUN and DONE.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- A prog_we in IDLE that coincides with an accept is committed before the first gate executes.

## Configuration
- **REV_INVERSE_EN defined:** in_inv selects the reverse order len−1…0. Because every gate is self-inverse, running inverse on a forward result recovers the original word.
- **REV_INVERSE_EN undefined:** in_inv is ignored, pc always counts up, and the decrement path is not built.

## Structure
- **rev_gate_pkg** holds:
  - the gate-type enum (GT_NOP, GT_TOFFOLI, GT_FREDKIN)
  - the FSM state enum (S_IDLE, S_RUN, S_DONE)
  - the packed gate-entry struct, parametrised through the module with WIDTH/IDXW.
- **Sub-module rev_gate_apply** is combinational: it takes (state, entry) and returns next_state. It contains the control check, the NOP-degeneracy rules and the flip/swap. The engine instantiates it once.

## Test plan
All values use WIDTH=8.
- **Reset:** assert rst at any time → in_ready=1, out_valid=0, out_data=0x00, busy=0.
- **Toffoli:** entry0 = TOFFOLI, ctrl=0x03, tgt_a=2, len=1.
  - in 0x03 → out 0x07, out_valid at E+2.
  - in 0x01 → out 0x01.
- **Fredkin:** entry0 = FREDKIN, ctrl=0x01, tgt 1/2, len=1.
  - in 0x03 → out 0x05.
  - in 0x02 → out 0x02.
- **Reversibility (REV_INVERSE_EN):** program 3 mixed gates, len=3. Forward on 0xA5 gives X. X with in_inv=1 → 0xA5, each run taking 4 cycles to out_valid.
- **Backpressure and writes:** hold out_ready=0 for 5 cycles → out_data stable and in_ready=0. A prog_we during RUN does not alter the next run's result.
- **Boundaries:**
  - prog_len=0 → in_data echoed at E+1.
  - prog_len=DEPTH+3 → executes exactly DEPTH gates.
  - rst pulsed mid-RUN → IDLE and 0x00 output, with no stale out_valid.

Source files
------------

// File: rtl/rev_gate_pkg.sv
// Shared types for the reversible gate engine: gate-type and FSM enums, entry sizing helper.
package rev_gate_pkg;

  typedef enum logic [1:0] {
    GT_NOP     = 2'b00,
    GT_TOFFOLI = 2'b01,
    GT_FREDKIN = 2'b10
  } gate_type_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } fsm_state_e;

  // Packed entry layout {gtype[1:0], ctrl[WIDTH-1:0], tgt_a[IDXW-1:0], tgt_b[IDXW-1:0]}
  function automatic int unsigned entry_bits(int unsigned width, int unsigned idxw);
    return 2 + width + 2 * idxw;
  endfunction

endpackage

// File: rtl/rev_gate_apply.sv
// Combinational single-gate step: control check, degenerate-entry NOP rules, Toffoli flip or
// Fredkin swap.
module rev_gate_apply
  import rev_gate_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned IDXW   = $clog2(WIDTH),
  parameter int unsigned EntryW = entry_bits(WIDTH, IDXW)
) (
  input  logic [WIDTH-1:0]  state_i,
  input  logic [EntryW-1:0] entry_i,
  output logic [WIDTH-1:0]  state_o
);

  typedef struct packed {
    logic [1:0]       gtype;
    logic [WIDTH-1:0] ctrl;
    logic [IDXW-1:0]  tgt_a;
    logic [IDXW-1:0]  tgt_b;
  } gate_entry_t;

  gate_entry_t      e;
  logic [WIDTH-1:0] one, bit_a, bit_b;
  logic             ctrl_ok, clash_a, clash_b, bits_differ;

  always_comb begin
    e       = gate_entry_t'(entry_i);
    one     = {{(WIDTH-1){1'b0}}, 1'b1};
    // Out-of-range targets shift to an all-zero mask, which the checks below treat as NOP
    bit_a   = one << e.tgt_a;
    bit_b   = one << e.tgt_b;
    ctrl_ok = (state_i & e.ctrl) == e.ctrl;
    clash_a = |(e.ctrl & bit_a);
    clash_b = |(e.ctrl & bit_b);
    bits_differ = (|(state_i & bit_a)) != (|(state_i & bit_b));
    state_o = state_i;
    if (ctrl_ok && !clash_a && (bit_a != '0)) begin
      case (e.gtype)
        GT_TOFFOLI: state_o = state_i ^ bit_a;
        GT_FREDKIN: begin
          if ((bit_b != '0) && (bit_a != bit_b) && !clash_b && bits_differ) begin
            state_o = state_i ^ bit_a ^ bit_b;
          end
        end
        default: state_o = state_i;
      endcase
    end
  end

endmodule

// File: rtl/rev_gate_engine.sv
// Sequential reversible-logic engine: applies up to DEPTH programmed gates, one per clock.
// Optional macro REV_INVERSE_EN enables running the program in reverse (uncompute).
module rev_gate_engine
  import rev_gate_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDXW  = $clog2(WIDTH),
  parameter int unsigned ADRW  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic [ADRW-1:0]   prog_addr,
  input  logic [1:0]        prog_type,
  input  logic [WIDTH-1:0]  prog_ctrl,
  input  logic [IDXW-1:0]   prog_tgt_a,
  input  logic [IDXW-1:0]   prog_tgt_b,
  input  logic [ADRW:0]     prog_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_inv,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              busy
);

  localparam int unsigned EntryW = entry_bits(WIDTH, IDXW);
  localparam int unsigned LenW   = ADRW + 1;

  typedef struct packed {
    logic [1:0]       gtype;
    logic [WIDTH-1:0] ctrl;
    logic [IDXW-1:0]  tgt_a;
    logic [IDXW-1:0]  tgt_b;
  } gate_entry_t;

  fsm_state_e       fsm_q, fsm_d;
  logic [WIDTH-1:0] data_q, data_d, gate_out;
  logic [ADRW-1:0]  pc_q, pc_d;
  logic [LenW-1:0]  cnt_q, cnt_d, len_clip;
  gate_entry_t      prog_q [DEPTH];
  gate_entry_t      prog_d [DEPTH];

`ifdef REV_INVERSE_EN
  logic inv_q, inv_d;
`else
  logic unused_inv;
  assign unused_inv = in_inv;
`endif

  rev_gate_apply #(
    .WIDTH  (WIDTH),
    .IDXW   (IDXW),
    .EntryW (EntryW)
  ) u_apply (
    .state_i (data_q),
    .entry_i (prog_q[pc_q]),
    .state_o (gate_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm_q <= S_IDLE;
    else     fsm_q <= fsm_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      pc_q   <= '0;
      cnt_q  <= '0;
`ifdef REV_INVERSE_EN
      inv_q  <= 1'b0;
`endif
      for (int i = 0; i < DEPTH; i++) prog_q[i] <= '0;
    end else begin
      data_q <= data_d;
      pc_q   <= pc_d;
      cnt_q  <= cnt_d;
`ifdef REV_INVERSE_EN
      inv_q  <= inv_d;
`endif
      prog_q <= prog_d;
    end
  end

  // Program writes only land in IDLE so the list is frozen for the whole run
  always_comb begin
    prog_d = prog_q;
    if (prog_we && (fsm_q == S_IDLE) && (32'(prog_addr) < DEPTH)) begin
      prog_d[prog_addr] = '{gtype: prog_type, ctrl: prog_ctrl,
                            tgt_a: prog_tgt_a, tgt_b: prog_tgt_b};
    end
  end

  always_comb begin
    len_clip = (prog_len > LenW'(DEPTH)) ? LenW'(DEPTH) : prog_len;
    fsm_d    = fsm_q;
    data_d   = data_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
`ifdef REV_INVERSE_EN
    inv_d    = inv_q;
`endif
    unique case (fsm_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d = in_data;
          cnt_d  = len_clip;
`ifdef REV_INVERSE_EN
          inv_d  = in_inv;
          pc_d   = in_inv ? ADRW'(len_clip - LenW'(1)) : '0;
`else
          pc_d   = '0;
`endif
          fsm_d  = (len_clip == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        data_d = gate_out;
        cnt_d  = cnt_q - LenW'(1);
`ifdef REV_INVERSE_EN
        pc_d   = inv_q ? (pc_q - ADRW'(1)) : (pc_q + ADRW'(1));
`else
        pc_d   = pc_q + ADRW'(1);
`endif
        if (cnt_q == LenW'(1)) fsm_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) fsm_d = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (fsm_q == S_IDLE);
    out_valid = (fsm_q == S_DONE);
    busy      = (fsm_q != S_IDLE);
    out_data  = out_valid ? data_q : '0;
  end

endmodule

// File: tb/tb_rev_gate_engine.sv
// Scoreboard bench for rev_gate_engine: directed gate cases plus randomized programs checked
// against a bit-level reference model.
module tb_rev_gate_engine;

  localparam int W = 8;
  localparam int D = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [1:0] prog_type = '0;
  logic [7:0] prog_ctrl = '0;
  logic [2:0] prog_tgt_a = '0, prog_tgt_b = '0;
  logic [4:0] prog_len = '0;
  logic       in_valid = 1'b0, in_inv = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready, out_valid, busy;
  logic [7:0] out_data;

  rev_gate_engine dut (
    .clk        (clk),
    .rst        (rst),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_type  (prog_type),
    .prog_ctrl  (prog_ctrl),
    .prog_tgt_a (prog_tgt_a),
    .prog_tgt_b (prog_tgt_b),
    .prog_len   (prog_len),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_inv     (in_inv),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] data;
    int         acc;
    int         len;
  } exp_t;
  exp_t sb[$];

  // Reference program image
  logic [1:0] m_type [D];
  logic [7:0] m_ctrl [D];
  int         m_a [D];
  int         m_b [D];

  int rdy_mode = 2;  // 0 hold low, 1 random, 2 high

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  function automatic logic [7:0] ref_gate(input logic [7:0] w, input int i);
    logic [7:0] c;
    logic       tmp;
    int         a, b;
    c = m_ctrl[i];
    a = m_a[i];
    b = m_b[i];
    if ((w & c) != c) return w;
    if (m_type[i] == 2'd1) begin
      if (a >= W || c[a]) return w;
      w[a] = ~w[a];
    end else if (m_type[i] == 2'd2) begin
      if (a >= W || b >= W || a == b || c[a] || c[b]) return w;
      tmp  = w[a];
      w[a] = w[b];
      w[b] = tmp;
    end
    return w;
  endfunction

  function automatic logic [7:0] ref_run(input logic [7:0] w, input int len, input bit inv);
    int n;
    n = (len > D) ? D : len;
    for (int k = 0; k < n; k++) w = ref_gate(w, inv ? (n - 1 - k) : k);
    return w;
  endfunction

  function automatic bit inv_eff(input bit inv);
`ifdef REV_INVERSE_EN
    return inv;
`else
    return 1'b0;
`endif
  endfunction

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) timeout_fail("wait_idle");
  endtask

  task automatic prog(input int addr, input logic [1:0] t, input logic [7:0] c,
                      input int a, input int b);
    @(negedge clk);
    prog_we    = 1'b1;
    prog_addr  = addr[3:0];
    prog_type  = t;
    prog_ctrl  = c;
    prog_tgt_a = a[2:0];
    prog_tgt_b = b[2:0];
    m_type[addr] = t;
    m_ctrl[addr] = c;
    m_a[addr]    = a;
    m_b[addr]    = b;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic prog_random();
    for (int i = 0; i < D; i++) begin
      prog(i, 2'($urandom_range(0, 3)), 8'($urandom() & $urandom()),
           $urandom_range(0, 7), $urandom_range(0, 7));
    end
  endtask

  task automatic send(input logic [7:0] d, input int len, input bit inv, input logic [7:0] exp);
    int tries = 0;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    prog_len = 5'(len);
    in_inv   = inv;
    while (!in_ready && tries < 500) begin
      @(negedge clk);
      tries++;
    end
    if (!in_ready) begin
      timeout_fail("accept");
      in_valid = 1'b0;
      return;
    end
    e.data = exp;
    e.acc  = cyc + 1;
    e.len  = (len > D) ? D : len;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // out_ready changes just after the rising edge so the negedge monitor sees what the DUT samples
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
    end
  end

  bit seen = 1'b0;
  int first_cyc = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      seen = 1'b0;
    end else begin
      if (out_valid && !seen) begin
        seen = 1'b1;
        first_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          timeout_fail("unexpected_output");
        end else begin
          e = sb.pop_front();
          check("out_data", out_data, e.data);
          check("latency", first_cyc, e.acc + e.len);
        end
        seen = 1'b0;
      end
    end
  end

  initial begin
    logic [7:0] d, x;
    int len;
    bit inv;
    for (int i = 0; i < D; i++) begin
      m_type[i] = 2'd0; m_ctrl[i] = 8'h00; m_a[i] = 0; m_b[i] = 0;
    end

    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    // Toffoli
    prog(0, 2'd1, 8'h03, 2, 0);
    send(8'h03, 1, 1'b0, 8'h07);
    send(8'h01, 1, 1'b0, 8'h01);
    wait_idle();

    // Fredkin
    prog(0, 2'd2, 8'h01, 1, 2);
    send(8'h03, 1, 1'b0, 8'h05);
    send(8'h02, 1, 1'b0, 8'h02);
    send(8'h5A, 0, 1'b0, 8'h5A);
    wait_idle();

    // Mixed three-gate program for reversibility and write-drop checks
    prog(0, 2'd1, 8'h81, 3, 0);
    prog(1, 2'd2, 8'h04, 0, 6);
    prog(2, 2'd1, 8'h00, 7, 0);
    send(8'hA5, 3, 1'b0, 8'h6C);
`ifdef REV_INVERSE_EN
    send(8'h6C, 3, 1'b1, 8'hA5);
`else
    send(8'h6C, 3, 1'b1, ref_run(8'h6C, 3, 1'b0));
`endif
    wait_idle();

    // Backpressure, with a program write attempted mid-run
    rdy_mode = 0;
    send(8'hA5, 3, 1'b0, 8'h6C);
    prog_we = 1'b1; prog_addr = 4'd0; prog_type = 2'd1; prog_ctrl = 8'h00; prog_tgt_a = 3'd0;
    @(negedge clk);
    prog_we = 1'b0;
    begin
      int n = 0;
      while (!out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!out_valid) timeout_fail("bp_wait_valid");
    end
    repeat (5) begin
      @(negedge clk);
      check("bp_out_data", out_data, 8'h6C);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    rdy_mode = 2;
    wait_idle();
    send(8'hA5, 3, 1'b0, 8'h6C);
    wait_idle();

    // Over-long length clips to DEPTH gates
    prog_random();
    d = 8'($urandom());
    send(d, D + 3, 1'b0, ref_run(d, D + 3, 1'b0));
    wait_idle();

    // Randomized runs with random backpressure
    rdy_mode = 1;
    for (int r = 0; r < 40; r++) begin
      if (r % 8 == 0) begin
        wait_idle();
        prog_random();
      end
      d   = 8'($urandom());
      len = $urandom_range(0, D + 3);
      inv = 1'($urandom_range(0, 1));
      send(d, len, inv, ref_run(d, len, inv_eff(inv)));
    end
`ifdef REV_INVERSE_EN
    wait_idle();
    d = 8'($urandom());
    x = ref_run(d, 12, 1'b0);
    send(d, 12, 1'b0, x);
    send(x, 12, 1'b1, d);
`endif
    wait_idle();

    // Reset mid-run
    rdy_mode = 2;
    send(8'h3C, 12, 1'b0, ref_run(8'h3C, 12, 1'b0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_busy", busy, 0);
    sb.delete();
    for (int i = 0; i < D; i++) begin
      m_type[i] = 2'd0; m_ctrl[i] = 8'h00; m_a[i] = 0; m_b[i] = 0;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_busy", busy, 0);
    // Program was cleared to NOPs, so data passes through unchanged
    send(8'hC3, 5, 1'b0, 8'hC3);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
